// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a registered req/ready/valid fetch port, optional wait states,
// a program-load write port, clear-on-reset, fault reporting and an accepted-fetch counter.
module instr_mem_ctrl #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned WAIT_STATES    = 0,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013),
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned IDX_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [1:0]        fetch_fault,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              busy,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {StInit, StIdle, StWait, StResp} state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q;
  logic [IDX_W-1:0]  clr_idx_q;
  logic [2:0]        wait_cnt_q;
  logic [DATA_W-1:0] word_q;
  logic [1:0]        fault_q;
  logic              valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [1:0]        fault_out_q;
  logic [31:0]       cnt_q;

  logic [IDX_W-1:0]  fetch_idx;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        req_fault;
  logic [DATA_W-1:0] acc_word;
  logic              accept;

  assign fetch_idx   = fetch_pc[IDX_W+1:2];
  assign word_addr   = {2'b00, fetch_pc[ADDR_W-1:2]};
  assign req_fault   = {word_addr >= ADDR_W'(DEPTH), fetch_pc[1:0] != 2'b00};
  // NOP substitution is resolved at acceptance so the response path only forwards a register.
  assign acc_word    = (req_fault != 2'b00) ? NOP_INSTR : mem[fetch_idx];
  assign fetch_ready = (state_q == StIdle) || (state_q == StResp);
  assign accept      = fetch_req && fetch_ready;
  assign busy        = (state_q == StInit);
  assign fetch_valid = valid_q;
  assign fetch_instr = instr_q;
  assign fetch_fault = fault_out_q;
  assign fetch_cnt   = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? StInit : StIdle;
      clr_idx_q   <= '0;
      wait_cnt_q  <= '0;
      word_q      <= NOP_INSTR;
      fault_q     <= 2'b00;
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      fault_out_q <= 2'b00;
      cnt_q       <= 32'd0;
    end else begin
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      fault_out_q <= 2'b00;
      if (accept) begin
        cnt_q   <= cnt_q + 32'd1;
        word_q  <= acc_word;
        fault_q <= req_fault;
      end
      unique case (state_q)
        StInit: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == IDX_W'(DEPTH - 1)) state_q <= StIdle;
        end
        StIdle, StResp: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state_q     <= StResp;
              valid_q     <= 1'b1;
              instr_q     <= acc_word;
              fault_out_q <= req_fault;
            end else begin
              state_q    <= StWait;
              wait_cnt_q <= 3'd0;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (wait_cnt_q == 3'(WAIT_STATES - 1)) begin
            state_q     <= StResp;
            valid_q     <= 1'b1;
            instr_q     <= word_q;
            fault_out_q <= fault_q;
          end else begin
            wait_cnt_q <= wait_cnt_q + 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array has no reset; INIT zero-fills it one word per cycle and locks out the program port.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == StInit) begin
        mem[clr_idx_q] <= '0;
      end else if (prog_we) begin
        mem[prog_addr] <= prog_data;
      end
    end
  end

endmodule
